// File: rtl/div16_if.sv
// Request/response bundle shared by the divider and whatever drives it.
interface div16_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 start;
  logic                 signed_op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic [2*WIDTH-1:0]   out;
  logic                 ready;
  logic                 busy;
  logic                 div_zero;

  modport master (
    output start, signed_op, a, b,
    input  out, ready, busy, div_zero
  );

  modport slave (
    input  start, signed_op, a, b,
    output out, ready, busy, div_zero
  );
endinterface

// File: rtl/div16.sv
// Multi-cycle restoring divider: one quotient bit per clock on magnitudes,
// then a single sign-fix cycle. Result format {remainder, quotient}.
module div16 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic   clk,
  input  logic   reset,
  div16_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t state, state_nx;

  logic                sop, sop_nx;
  logic                sa, sa_nx;
  logic                sb, sb_nx;
  logic [WIDTH-1:0]    dvd, dvd_nx;
  logic [WIDTH-1:0]    dsr, dsr_nx;
  logic [WIDTH-1:0]    rem, rem_nx;
  logic [WIDTH-1:0]    a_raw, a_raw_nx;
  logic [CW-1:0]       cnt, cnt_nx;
  logic [2*WIDTH-1:0]  out_q, out_nx;
  logic                ready_q, ready_nx;
  logic                busy_q, busy_nx;
  logic                dz_q, dz_nx;

  logic                accept_c;
  logic [WIDTH:0]      shifted_c;
  logic [WIDTH:0]      diff_c;
  logic [WIDTH-1:0]    q_fix_c;
  logic [WIDTH-1:0]    r_fix_c;

  assign accept_c  = bus.start && ((state == IDLE) || (state == DONE));
  assign shifted_c = {rem, dvd[WIDTH-1]};
  assign diff_c    = shifted_c - {1'b0, dsr};
  assign q_fix_c   = (sop && (sa ^ sb)) ? (~dvd) + WIDTH'(1) : dvd;
  assign r_fix_c   = (sop && sa)        ? (~rem) + WIDTH'(1) : rem;

  assign bus.out      = out_q;
  assign bus.ready    = ready_q;
  assign bus.busy     = busy_q;
  assign bus.div_zero = dz_q;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; a zero divisor skips iteration and the sign fix
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept_c) state_nx = RUN;
      RUN: begin
        if (dz_q)                          state_nx = DONE;
        else if (cnt == CW'(WIDTH - 1))    state_nx = FIX;
      end
      FIX:  state_nx = DONE;
      DONE: if (accept_c) state_nx = RUN;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    sop_nx   = sop;
    sa_nx    = sa;
    sb_nx    = sb;
    dvd_nx   = dvd;
    dsr_nx   = dsr;
    rem_nx   = rem;
    a_raw_nx = a_raw;
    cnt_nx   = cnt;
    out_nx   = out_q;
    ready_nx = ready_q;
    busy_nx  = busy_q;
    dz_nx    = dz_q;
    if (accept_c) begin
      sop_nx   = bus.signed_op;
      sa_nx    = bus.signed_op & bus.a[WIDTH-1];
      sb_nx    = bus.signed_op & bus.b[WIDTH-1];
      dvd_nx   = (bus.signed_op && bus.a[WIDTH-1]) ? (~bus.a) + WIDTH'(1) : bus.a;
      dsr_nx   = (bus.signed_op && bus.b[WIDTH-1]) ? (~bus.b) + WIDTH'(1) : bus.b;
      rem_nx   = '0;
      cnt_nx   = '0;
      a_raw_nx = bus.a;
      ready_nx = 1'b0;
      busy_nx  = 1'b1;
      dz_nx    = (bus.b == '0);
    end else begin
      case (state)
        RUN: begin
          if (dz_q) begin
            out_nx   = {a_raw, {WIDTH{1'b1}}};
            ready_nx = 1'b1;
            busy_nx  = 1'b0;
          end else begin
            // diff_c MSB set means the trial subtraction went negative: restore
            if (!diff_c[WIDTH]) begin
              rem_nx = diff_c[WIDTH-1:0];
              dvd_nx = {dvd[WIDTH-2:0], 1'b1};
            end else begin
              rem_nx = shifted_c[WIDTH-1:0];
              dvd_nx = {dvd[WIDTH-2:0], 1'b0};
            end
            cnt_nx = cnt + CW'(1);
          end
        end
        FIX: begin
          out_nx   = {r_fix_c, q_fix_c};
          ready_nx = 1'b1;
          busy_nx  = 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sop     <= 1'b0;
      sa      <= 1'b0;
      sb      <= 1'b0;
      dvd     <= '0;
      dsr     <= '0;
      rem     <= '0;
      a_raw   <= '0;
      cnt     <= '0;
      out_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      sop     <= sop_nx;
      sa      <= sa_nx;
      sb      <= sb_nx;
      dvd     <= dvd_nx;
      dsr     <= dsr_nx;
      rem     <= rem_nx;
      a_raw   <= a_raw_nx;
      cnt     <= cnt_nx;
      out_q   <= out_nx;
      ready_q <= ready_nx;
      busy_q  <= busy_nx;
      dz_q    <= dz_nx;
    end
  end

endmodule
